// File: rtl/capa_salida_rr.sv
// Egress stage: round-robin drains four blue FIFOs onto one tagged 12-bit valid/ready link (`SALIDA_PARITY_EN adds parity).
// Latency: ARB decision at t, pop at t+1, valid_out at t+3; at most one word per 4 cycles.
// Backpressure: SEND holds the word stable until ready_in; no new pop is issued meanwhile.
module capa_salida_rr #(
  parameter int DW    = 12,
  parameter int NPORT = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Enable,
  input  logic [NPORT-1:0] empty_azul,
  input  logic [DW-1:0]    data_azul_p0,
  input  logic [DW-1:0]    data_azul_p1,
  input  logic [DW-1:0]    data_azul_p2,
  input  logic [DW-1:0]    data_azul_p3,
  output logic [NPORT-1:0] pop_azul,
  output logic [DW-1:0]    data_out,
  output logic [1:0]       port_out,
  output logic             valid_out,
  input  logic             ready_in,
  output logic             misroute,
  output logic [CNT_W-1:0] word_cnt,
  output logic             idle
`ifdef SALIDA_PARITY_EN
  ,
  input  logic [NPORT-1:0] par_in,
  output logic             par_out,
  output logic             par_err_seen
`endif
);

  typedef enum logic [1:0] {ARB, POP, CAP, SEND} state_t;

  state_t          state, state_nxt;
  logic [1:0]      sel, rr_ptr, grant, cand;
  logic            grant_vld;
  logic [DW-1:0]   data_azul [NPORT];
  logic [DW-1:0]   word_sel;

  assign data_azul[0] = data_azul_p0;
  assign data_azul[1] = data_azul_p1;
  assign data_azul[2] = data_azul_p2;
  assign data_azul[3] = data_azul_p3;
  assign word_sel     = data_azul[sel];

  // Search starts just after the last served port; i=4 wraps back to rr_ptr itself.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    cand      = '0;
    for (int i = 1; i <= NPORT; i++) begin
      cand = rr_ptr + 2'(i);
      if (!grant_vld && !empty_azul[cand]) begin
        grant     = cand;
        grant_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    pop_azul  = '0;
    case (state)
      ARB:  if (Enable && grant_vld) state_nxt = POP;
      POP: begin
        pop_azul[sel] = 1'b1;
        state_nxt     = CAP;
      end
      CAP:  state_nxt = SEND;
      SEND: if (ready_in) state_nxt = ARB;
      default: state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ARB;
    else       state <= state_nxt;
  end

  // Reset during POP/CAP/SEND drops the in-flight word; the FIFO has already been popped.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel          <= '0;
      rr_ptr       <= 2'd3;
      data_out     <= '0;
      port_out     <= '0;
      valid_out    <= 1'b0;
      misroute     <= 1'b0;
      word_cnt     <= '0;
`ifdef SALIDA_PARITY_EN
      par_out      <= 1'b0;
      par_err_seen <= 1'b0;
`endif
    end else begin
      case (state)
        ARB: if (Enable && grant_vld) sel <= grant;
        CAP: begin
          data_out  <= word_sel;
          port_out  <= sel;
          valid_out <= 1'b1;
          if (word_sel[9:8] != sel) misroute <= 1'b1;
`ifdef SALIDA_PARITY_EN
          par_out <= ^word_sel;
          if ((^word_sel) != par_in[sel]) par_err_seen <= 1'b1;
`endif
        end
        SEND: begin
          if (ready_in) begin
            valid_out <= 1'b0;
            rr_ptr    <= sel;
            word_cnt  <= word_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign idle = (state == ARB) && (&empty_azul);

endmodule

// File: tb/tb_capa_salida_rr.sv
// Bench for capa_salida_rr: behavioural FIFO models feed the DUT, a scoreboard checks each accepted egress word.
module tb_capa_salida_rr;

  typedef struct packed {
    logic [1:0]  port;
    logic [11:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Enable = 1'b0;
  logic        ready_in = 1'b0;
  logic [3:0]  empty_azul;
  logic [11:0] data_r [4];
  logic [3:0]  pop_azul;
  logic [11:0] data_out;
  logic [1:0]  port_out;
  logic        valid_out;
  logic        misroute;
  logic [7:0]  word_cnt;
  logic        idle;
`ifdef SALIDA_PARITY_EN
  logic [3:0]  par_in;
  logic        par_out;
  logic        par_err_seen;
  assign par_in = {^data_r[3], ^data_r[2], ^data_r[1], ^data_r[0]};
`endif

  logic [11:0] fq [4][$];
  exp_t        exp_q [$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  capa_salida_rr dut (
    .clk          (clk),
    .reset        (reset),
    .Enable       (Enable),
    .empty_azul   (empty_azul),
    .data_azul_p0 (data_r[0]),
    .data_azul_p1 (data_r[1]),
    .data_azul_p2 (data_r[2]),
    .data_azul_p3 (data_r[3]),
    .pop_azul     (pop_azul),
    .data_out     (data_out),
    .port_out     (port_out),
    .valid_out    (valid_out),
    .ready_in     (ready_in),
    .misroute     (misroute),
    .word_cnt     (word_cnt),
    .idle         (idle)
`ifdef SALIDA_PARITY_EN
    ,
    .par_in       (par_in),
    .par_out      (par_out),
    .par_err_seen (par_err_seen)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int p, input logic [11:0] w, input bit expect_out);
    exp_t e;
    fq[p].push_back(w);
    if (expect_out) begin
      e.port = 2'(p);
      e.data = w;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_drain(input string nm, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk({nm, "_drain_done"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_pop(input string nm, input int budget);
    int n = 0;
    while (pop_azul == 4'b0 && n < budget) begin
      tick();
      n++;
    end
    chk({nm, "_pop_seen"}, 32'(pop_azul != 4'b0), 32'd1);
  endtask

  task automatic stimulus();
    int bad;
    // 1: reset with random control inputs
    repeat (2) begin
      Enable   = 1'($urandom_range(0, 1));
      ready_in = 1'($urandom_range(0, 1));
      tick();
    end
    chk("rst_pop", 32'(pop_azul), 32'd0);
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_cnt", 32'(word_cnt), 32'd0);
    chk("rst_misroute", 32'(misroute), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    reset = 1'b0; Enable = 1'b1; ready_in = 1'b1;

    // 2: single word on p2
    push(2, 12'h6A5, 1'b1);
    wait_pop("single", 20);
    chk("single_pop", 32'(pop_azul), 32'h4);
    tick();
    chk("single_pop_one_cycle", 32'(pop_azul), 32'd0);
    chk("single_not_yet_valid", 32'(valid_out), 32'd0);
    tick();
    chk("single_valid_t2", 32'(valid_out), 32'd1);
    tick();
    chk("single_cnt", 32'(word_cnt), 32'd1);

    // 3: round robin from a fresh reset, two words per port
    reset = 1'b1; tick(); reset = 1'b0;
    push(0, 12'h012, 1'b0); push(0, 12'hC34, 1'b0);
    push(1, 12'h155, 1'b0); push(1, 12'h5AA, 1'b0);
    push(2, 12'h266, 1'b0); push(2, 12'hA99, 1'b0);
    push(3, 12'h377, 1'b0); push(3, 12'hF88, 1'b0);
    exp_q.push_back('{2'd0, 12'h012}); exp_q.push_back('{2'd1, 12'h155});
    exp_q.push_back('{2'd2, 12'h266}); exp_q.push_back('{2'd3, 12'h377});
    exp_q.push_back('{2'd0, 12'hC34}); exp_q.push_back('{2'd1, 12'h5AA});
    exp_q.push_back('{2'd2, 12'hA99}); exp_q.push_back('{2'd3, 12'hF88});
    wait_drain("rr", 200);
    tick(); tick();
    chk("rr_cnt", 32'(word_cnt), 32'd8);
    chk("rr_idle", 32'(idle), 32'd1);
    chk("rr_misroute", 32'(misroute), 32'd0);

    // 4: backpressure held 10 cycles in SEND
    ready_in = 1'b0;
    push(1, 12'h1C3, 1'b1);
    push(2, 12'h2D4, 1'b1);
    begin
      int n = 0;
      while (!valid_out && n < 20) begin tick(); n++; end
    end
    chk("bp_valid_seen", 32'(valid_out), 32'd1);
    bad = 0;
    repeat (10) begin
      tick();
      if (data_out !== 12'h1C3 || port_out !== 2'd1 || valid_out !== 1'b1 || pop_azul !== 4'b0) bad++;
    end
    chk("bp_stable_cycles_bad", 32'(bad), 32'd0);
    chk("bp_cnt_held", 32'(word_cnt), 32'd8);
    ready_in = 1'b1;
    tick();
    chk("bp_valid_drop", 32'(valid_out), 32'd0);
    chk("bp_cnt_plus1", 32'(word_cnt), 32'd9);
    chk("bp_no_pop_in_arb", 32'(pop_azul), 32'd0);
    tick();
    chk("bp_next_pop", 32'(pop_azul), 32'h4);
    wait_drain("bp", 50);

    // 5: misrouted word is forwarded and flagged stickily
    push(1, 12'h300, 1'b1);
    wait_drain("mis", 50);
    tick();
    chk("mis_set", 32'(misroute), 32'd1);
    push(0, 12'h0AB, 1'b1);
    wait_drain("mis2", 50);
    tick();
    chk("mis_sticky", 32'(misroute), 32'd1);
    chk("mis_cnt", 32'(word_cnt), 32'd12);

    // 6a: Enable dropped during POP
    push(3, 12'h3E1, 1'b1);
    push(0, 12'h042, 1'b1);
    wait_pop("en", 20);
    chk("en_pop_p3", 32'(pop_azul), 32'h8);
    Enable = 1'b0;
    bad = 0;
    repeat (20) begin
      tick();
      if (pop_azul !== 4'b0) bad++;
    end
    chk("en_no_new_pop", 32'(bad), 32'd0);
    chk("en_inflight_done", 32'(exp_q.size()), 32'd1);
    chk("en_cnt", 32'(word_cnt), 32'd13);
    Enable = 1'b1;
    wait_drain("en", 50);
    tick();
    chk("en_cnt_after", 32'(word_cnt), 32'd14);

    // 6b: reset asserted in CAP discards the popped word
    push(2, 12'h2F0, 1'b0);
    wait_pop("rcap", 20);
    tick();
    reset = 1'b1;
    tick();
    chk("rcap_valid", 32'(valid_out), 32'd0);
    chk("rcap_cnt", 32'(word_cnt), 32'd0);
    chk("rcap_misroute", 32'(misroute), 32'd0);
    reset = 1'b0;
    bad = 0;
    repeat (6) begin
      tick();
      if (valid_out !== 1'b0) bad++;
    end
    chk("rcap_word_dropped", 32'(bad), 32'd0);
    chk("rcap_idle", 32'(idle), 32'd1);
`ifdef SALIDA_PARITY_EN
    chk("par_err_clear", 32'(par_err_seen), 32'd0);
`endif
  endtask

  initial begin
    logic [11:0] w;
    exp_t        e;
    empty_azul = 4'hF;
    for (int i = 0; i < 4; i++) data_r[i] = '0;
    fork
      // FIFO models: data appears the cycle after the pop, empty is registered
      forever begin
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
          if (pop_azul[i]) begin
            if (fq[i].size() == 0) begin
              checks++; errors++;
              $display("FAIL pop_of_empty_fifo: port %0d popped while empty", i);
            end else begin
              w = fq[i].pop_front();
              data_r[i] <= w;
            end
          end
        end
        for (int i = 0; i < 4; i++) empty_azul[i] <= (fq[i].size() == 0);
      end
      // scoreboard monitor
      forever begin
        @(negedge clk);
        if (!reset && valid_out && ready_in) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_word: got port %0d data %h, none expected", port_out, data_out);
          end else begin
            e = exp_q.pop_front();
            chk("egress_data", 32'(data_out), 32'(e.data));
            chk("egress_port", 32'(port_out), 32'(e.port));
`ifdef SALIDA_PARITY_EN
            chk("egress_parity", 32'(par_out), 32'(^e.data));
`endif
          end
        end
      end
      stimulus();
      begin
        repeat (20000) @(posedge clk);
        checks++; errors++;
        $display("FAIL watchdog: stimulus still running after 20000 cycles, expected completion");
      end
    join_any
    disable fork;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
